// File: rtl/iiitb_vm_multi_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package iiitb_vm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vm_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN1     = 2'b01;
    localparam logic [1:0] COIN2     = 2'b10;
    localparam logic [1:0] COIN3     = 2'b11;

    // Value of a coin code for a given set of denominations; COIN_NONE is worth 0.
    function automatic int coin_value(input logic [1:0] code, input int v1, input int v2,
                                      input int v3);
        case (code)
            COIN1:   return v1;
            COIN2:   return v2;
            COIN3:   return v3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/iiitb_vm_multi_if.sv
// Coin-acceptor / selection / dispenser bus of the vending controller.
interface iiitb_vm_multi_if #(
    parameter int N_ITEMS  = 4,
    parameter int CREDIT_W = 8
);
    localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic [1:0]          coin;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel;
    logic                cancel;
    logic                restock;
    logic                out;
    logic [SEL_W-1:0]    out_item;
    logic [1:0]          change;
    logic                coin_rej;
    logic                err;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic [N_ITEMS-1:0]  sold_out;

    modport master (
        output coin, sel_valid, sel, cancel, restock,
        input  out, out_item, change, coin_rej, err, busy, credit, sold_out
    );

    modport slave (
        input  coin, sel_valid, sel, cancel, restock,
        output out, out_item, change, coin_rej, err, busy, credit, sold_out
    );
endinterface

// File: rtl/iiitb_vm_stock.sv
// Per-item stock counters with decrement-on-vend, global restock and sold-out flags.
module iiitb_vm_stock #(
    parameter int N_ITEMS    = 4,
    parameter int SEL_W      = 2,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dec_en,
    input  logic [SEL_W-1:0]   dec_idx,
    input  logic               restock,
    output logic [N_ITEMS-1:0] sold_out
);
    localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0] stock_q [N_ITEMS];
    logic [STOCK_W-1:0] stock_d [N_ITEMS];
    logic [N_ITEMS-1:0] sold_out_q;
    logic [N_ITEMS-1:0] sold_out_d;

    // Next stock: restock overrides a same-cycle decrement; empty counters never wrap.
    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (restock) begin
                stock_d[i] = INIT_V;
            end else if (dec_en && (dec_idx == SEL_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    // Counters and registered sold-out flags, both reloaded on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= INIT_V;
            end
            sold_out_q <= {N_ITEMS{INIT_V == '0}};
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out = sold_out_q;
endmodule

// File: rtl/iiitb_vm_multi.sv
// Multi-item vending controller: credit accumulation, vend, greedy change and refund.
module iiitb_vm_multi
    import iiitb_vm_pkg::*;
#(
    parameter int                          N_ITEMS     = 4,
    parameter int                          CREDIT_W    = 8,
    parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {8'd40, 8'd25, 8'd20, 8'd15},
    parameter int                          COIN1_VAL   = 5,
    parameter int                          COIN2_VAL   = 10,
    parameter int                          COIN3_VAL   = 25,
    parameter int                          CREDIT_MAX  = 95,
    parameter int                          STOCK_W     = 4,
    parameter int                          STOCK_INIT  = 3
) (
    input logic              clock,
    input logic              reset,
    iiitb_vm_multi_if.slave  bus
);
    localparam int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam logic [CREDIT_W-1:0] C1 = CREDIT_W'(COIN1_VAL);
    localparam logic [CREDIT_W-1:0] C2 = CREDIT_W'(COIN2_VAL);
    localparam logic [CREDIT_W-1:0] C3 = CREDIT_W'(COIN3_VAL);
    localparam logic [CREDIT_W:0]   CMAX = (CREDIT_W+1)'(CREDIT_MAX);

    vm_state_e           state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                out_q, out_d;
    logic [SEL_W-1:0]    out_item_q, out_item_d;
    logic [1:0]          change_q, change_d;
    logic                coin_rej_q, coin_rej_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [N_ITEMS-1:0]  sold_out;
    logic                dec_en;
    logic [1:0]          greedy_code;
    logic [CREDIT_W-1:0] greedy_val;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] price;
    logic                sel_ok;

    iiitb_vm_stock #(
        .N_ITEMS   (N_ITEMS),
        .SEL_W     (SEL_W),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clock   (clock),
        .reset   (reset),
        .dec_en  (dec_en),
        .dec_idx (bus.sel),
        .restock (bus.restock),
        .sold_out(sold_out)
    );

    // Largest coin not exceeding the credit; a leftover smaller than every coin is dropped.
    always_comb begin
        greedy_code = COIN_NONE;
        greedy_val  = credit_q;
        if (credit_q >= C3) begin
            greedy_code = COIN3;
            greedy_val  = C3;
        end else if (credit_q >= C2) begin
            greedy_code = COIN2;
            greedy_val  = C2;
        end else if (credit_q >= C1) begin
            greedy_code = COIN1;
            greedy_val  = C1;
        end
    end

    // Price lookup and acceptance check for the requested item against registered credit.
    always_comb begin
        price  = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                price  = ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
                sel_ok = !sold_out[i] && (credit_q >= ITEM_PRICES[i*CREDIT_W +: CREDIT_W]);
            end
        end
    end

    // Controller next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        out_d      = 1'b0;
        out_item_d = '0;
        change_d   = COIN_NONE;
        coin_rej_d = 1'b0;
        err_d      = 1'b0;
        dec_en     = 1'b0;
        coin_val   = CREDIT_W'(coin_value(bus.coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
        coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};

        case (state_q)
            IDLE, COLLECT: begin
                if (bus.cancel) begin
                    coin_rej_d = (bus.coin != COIN_NONE);
                    if (state_q == COLLECT) begin
                        change_d = greedy_code;
                        credit_d = credit_q - greedy_val;
                        state_d  = CHANGE;
                    end
                end else if (bus.sel_valid) begin
                    coin_rej_d = (bus.coin != COIN_NONE);
                    if (sel_ok) begin
                        credit_d   = credit_q - price;
                        dec_en     = 1'b1;
                        out_d      = 1'b1;
                        out_item_d = bus.sel;
                        state_d    = VEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.coin != COIN_NONE) begin
                    if (coin_sum <= CMAX) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = COLLECT;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end
            VEND, CHANGE: begin
                coin_rej_d = (bus.coin != COIN_NONE);
                if (credit_q != '0) begin
                    change_d = greedy_code;
                    credit_d = credit_q - greedy_val;
                    state_d  = CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    // State, credit and output registers; credit is discarded on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            out_q      <= 1'b0;
            out_item_q <= '0;
            change_q   <= COIN_NONE;
            coin_rej_q <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            out_q      <= out_d;
            out_item_q <= out_item_d;
            change_q   <= change_d;
            coin_rej_q <= coin_rej_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.out_item = out_item_q;
    assign bus.change   = change_q;
    assign bus.coin_rej = coin_rej_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.credit   = credit_q;
    assign bus.sold_out = sold_out;
endmodule

// File: tb/tb_iiitb_vm_multi.sv
// Directed, table-driven bench for the multi-item vending controller (default parameters).
module tb_iiitb_vm_multi;
    import iiitb_vm_pkg::*;

    typedef struct {
        string      name;
        logic [1:0] coin;
        logic       sel_valid;
        logic [1:0] sel;
        logic       cancel;
        logic       restock;
        logic [7:0] credit;
        logic       out;
        logic [1:0] item;
        logic [1:0] change;
        logic       rej;
        logic       err;
        logic       busy;
        logic [3:0] sold;
    } vec_t;

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;
    vec_t vecs[$];

    iiitb_vm_multi_if #(.N_ITEMS(4), .CREDIT_W(8)) bus ();

    iiitb_vm_multi dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(string name, logic [1:0] coin, logic sv, logic [1:0] sel,
                                logic cn, logic rs, int cr, logic o, logic [1:0] it,
                                logic [1:0] ch, logic rj, logic er, logic bs, logic [3:0] so);
        vec_t v;
        v.name = name; v.coin = coin; v.sel_valid = sv; v.sel = sel; v.cancel = cn;
        v.restock = rs; v.credit = 8'(cr); v.out = o; v.item = it; v.change = ch;
        v.rej = rj; v.err = er; v.busy = bs; v.sold = so;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_all(input vec_t v);
        check_output({v.name, ".credit"},   32'(bus.credit),   32'(v.credit));
        check_output({v.name, ".out"},      32'(bus.out),      32'(v.out));
        check_output({v.name, ".out_item"}, 32'(bus.out_item), 32'(v.item));
        check_output({v.name, ".change"},   32'(bus.change),   32'(v.change));
        check_output({v.name, ".coin_rej"}, 32'(bus.coin_rej), 32'(v.rej));
        check_output({v.name, ".err"},      32'(bus.err),      32'(v.err));
        check_output({v.name, ".busy"},     32'(bus.busy),     32'(v.busy));
        check_output({v.name, ".sold_out"}, 32'(bus.sold_out), 32'(v.sold));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare the registered response.
    task automatic apply_stimulus(input vec_t v);
        bus.coin      = v.coin;
        bus.sel_valid = v.sel_valid;
        bus.sel       = v.sel;
        bus.cancel    = v.cancel;
        bus.restock   = v.restock;
        @(posedge clock);
        #1;
        check_all(v);
    endtask

    task automatic buy_item0(input string tag, input logic [3:0] so_before,
                             input logic [3:0] so_after);
        apply_stimulus(mk({tag, "_c10"},  COIN2,     0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, so_before));
        apply_stimulus(mk({tag, "_c5"},   COIN1,     0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, so_before));
        apply_stimulus(mk({tag, "_sel0"}, COIN_NONE, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, so_after));
        apply_stimulus(mk({tag, "_idle"}, COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, so_after));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        bus.coin = COIN_NONE; bus.sel_valid = 1'b0; bus.cancel = 1'b0; bus.restock = 1'b0;
        while (bus.busy === 1'b1 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_output({name, ".busy_drops"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset         = 1'b0;
        bus.coin      = COIN_NONE;
        bus.sel_valid = 1'b0;
        bus.sel       = '0;
        bus.cancel    = 1'b0;
        bus.restock   = 1'b0;

        // Main directed table: name, coin, sel_valid, sel, cancel, restock, then expected
        // credit, out, out_item, change, coin_rej, err, busy, sold_out.
        vecs.push_back(mk("exact_c10",   COIN2,     0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("exact_c5",    COIN1,     0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("exact_sel0",  COIN_NONE, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("exact_idle",  COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("over_c25a",   COIN3,     0, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("over_c25b",   COIN3,     0, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("over_sel1",   COIN_NONE, 1, 1, 0, 0, 30, 1, 1, 0, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("over_chg25",  COIN_NONE, 0, 0, 0, 0,  5, 0, 0, 3, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("over_chg5",   COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("over_idle",   COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("insuf_c10",   COIN2,     0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("insuf_sel3",  COIN_NONE, 1, 3, 0, 0, 10, 0, 0, 0, 0, 1, 0, 4'b0000));
        vecs.push_back(mk("insuf_sel0",  COIN_NONE, 1, 0, 0, 0, 10, 0, 0, 0, 0, 1, 0, 4'b0000));
        vecs.push_back(mk("so_c5",       COIN1,     0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("so_sel0a",    COIN_NONE, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("so_idle1",    COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("so_c25",      COIN3,     0, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("so_sel0b",    COIN_NONE, 1, 0, 0, 0, 10, 1, 0, 0, 0, 0, 1, 4'b0001));
        vecs.push_back(mk("so_chg10",    COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 1, 4'b0001));
        vecs.push_back(mk("so_idle2",    COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0001));
        vecs.push_back(mk("so_c5b",      COIN1,     0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 4'b0001));
        vecs.push_back(mk("so_c10",      COIN2,     0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 4'b0001));
        vecs.push_back(mk("so_sel0c",    COIN_NONE, 1, 0, 0, 0, 15, 0, 0, 0, 0, 1, 0, 4'b0001));
        vecs.push_back(mk("restock",     COIN_NONE, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("rs_sel0",     COIN_NONE, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("rs_idle",     COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c25a",     COIN3,     0, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c25b",     COIN3,     0, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c25c",     COIN3,     0, 0, 0, 0, 75, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c10",      COIN2,     0, 0, 0, 0, 85, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c5",       COIN1,     0, 0, 0, 0, 90, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c10_rej",  COIN2,     0, 0, 0, 0, 90, 0, 0, 0, 1, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c5_max",   COIN1,     0, 0, 0, 0, 95, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("ov_c5_rej",   COIN1,     0, 0, 0, 0, 95, 0, 0, 0, 1, 0, 0, 4'b0000));
        vecs.push_back(mk("cx_cancel",   COIN_NONE, 0, 0, 1, 0, 70, 0, 0, 3, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("cx_coin_bsy", COIN1,     0, 0, 0, 0, 45, 0, 0, 3, 1, 0, 1, 4'b0000));
        vecs.push_back(mk("cx_chg25",    COIN_NONE, 0, 0, 0, 0, 20, 0, 0, 3, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("cx_chg10a",   COIN_NONE, 0, 0, 0, 0, 10, 0, 0, 2, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("cx_chg10b",   COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("cx_idle",     COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("cs_c25",      COIN3,     0, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("cs_c10",      COIN2,     0, 0, 0, 0, 35, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("cs_cncl_sel", COIN_NONE, 1, 1, 1, 0, 10, 0, 0, 3, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("cs_chg10",    COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("cs_idle",     COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("idle_cancel", COIN_NONE, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("cr_c10",      COIN2,     0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 4'b0000));
        vecs.push_back(mk("cr_coin_sel", COIN1,     1, 3, 0, 0, 10, 0, 0, 0, 1, 1, 0, 4'b0000));
        vecs.push_back(mk("cr_cancel",   COIN_NONE, 0, 0, 1, 0,  0, 0, 0, 2, 0, 0, 1, 4'b0000));
        vecs.push_back(mk("cr_idle",     COIN_NONE, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 4'b0000));

        // Reset state while reset is held.
        #12;
        check_all(mk("reset_state", COIN_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Drain item 0 (two left) so it is sold out before the reset test.
        buy_item0("pre1", 4'b0000, 4'b0000);
        buy_item0("pre2", 4'b0000, 4'b0001);

        // Enter CHANGE with a refund of 50, then reset asynchronously between edges.
        apply_stimulus(mk("rst_c25a",   COIN3,     0, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0, 4'b0001));
        apply_stimulus(mk("rst_c25b",   COIN3,     0, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 4'b0001));
        apply_stimulus(mk("rst_cancel", COIN_NONE, 0, 0, 1, 0, 25, 0, 0, 3, 0, 0, 1, 4'b0001));
        bus.cancel = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_all(mk("async_reset", COIN_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        @(negedge clock);
        reset = 1'b1;

        // Stock must be back to three: only the third purchase sells item 0 out.
        buy_item0("post1", 4'b0000, 4'b0000);
        buy_item0("post2", 4'b0000, 4'b0000);
        buy_item0("post3", 4'b0000, 4'b0001);

        // Dearest item with change, then a bounded wait for the controller to go idle.
        apply_stimulus(mk("fin_c25a", COIN3,     0, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0, 4'b0001));
        apply_stimulus(mk("fin_c25b", COIN3,     0, 0, 0, 0, 50, 0, 0, 0, 0, 0, 0, 4'b0001));
        apply_stimulus(mk("fin_sel3", COIN_NONE, 1, 3, 0, 0, 10, 1, 3, 0, 0, 0, 1, 4'b0001));
        wait_idle("fin", 10);
        check_output("fin.credit", 32'(bus.credit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
